key_schedule_seq: RTL and testbench

- Iterative, sequential AES key-expansion engine. Generates one 32-bit schedule word per clock.
- Sits directly upstream of the Encrypt/Decrypt round engines. Its flat round-key bus feeds their expansion input in place of the combinational expander, trading ~40–52 cycles of latency for one shared SubWord path.
- Start/done handshake; the result stays held until the next start.

---
 rtl/key_schedule_seq.sv | 171 +++++++++++++++++
 tb/tb_key_schedule_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: iterative AES key expansion, one schedule word per clock.
// A single SubWord path serves both RotWord steps and the 256-bit mid-key step.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // entry 0 sits in the MSBs, so 255-a (== ~a) selects the byte
  assign y = TBL[{~a, 3'b000} +: 8];

endmodule

module key_schedule_seq #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NK*32-1:0]        key,
  output logic                    busy,
  output logic                    done,
  output logic                    valid,
  output logic [(NR+1)*128-1:0]   expansion
);

  localparam int W  = 4 * (NR + 1);
  localparam int IW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    FIN
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic [IW-1:0] i_q;
  logic [2:0]    k_q;
  logic [7:0]    rcon_q;
  logic [31:0]   win_q [NK];
  logic [31:0]   w_q   [W];

  logic          accept;
  logic          step;
  logic          last;
  logic [31:0]   prev;
  logic [31:0]   rot;
  logic [31:0]   sub_in;
  logic [31:0]   sub_out;
  logic [31:0]   temp;
  logic [31:0]   nw;
  logic [7:0]    rcon_nx;

  assign accept = (state_q == IDLE) && start;
  assign step   = (state_q == GEN);
  assign last   = step && (i_q == IW'(W - 1));

  // win_q holds w[i-NK] .. w[i-1]; oldest at index 0
  assign prev   = win_q[NK-1];
  assign rot    = {prev[23:0], prev[31:24]};
  assign sub_in = (k_q == 3'd0) ? rot : prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in[b*8 +: 8]),
      .y (sub_out[b*8 +: 8])
    );
  end

  assign rcon_nx = {rcon_q[6:0], 1'b0}
                 ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    temp = prev;
    if (k_q == 3'd0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if ((NK > 6) && (k_q == 3'd4)) begin
      temp = sub_out;
    end
  end

  assign nw = win_q[0] ^ temp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = GEN;
      GEN:  if (last)  state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == GEN);
    done = (state_q == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_q    <= '0;
      k_q    <= '0;
      rcon_q <= 8'h01;
      valid  <= 1'b0;
      for (int j = 0; j < NK; j++) begin
        win_q[j] <= '0;
      end
      for (int j = 0; j < W; j++) begin
        w_q[j] <= '0;
      end
    end else if (accept) begin
      for (int j = 0; j < NK; j++) begin
        win_q[j] <= key[(NK-j)*32-1 -: 32];
        w_q[j]   <= key[(NK-j)*32-1 -: 32];
      end
      i_q    <= IW'(NK);
      k_q    <= '0;
      rcon_q <= 8'h01;
      valid  <= 1'b0;
    end else if (step) begin
      w_q[i_q] <= nw;
      for (int j = 0; j < NK - 1; j++) begin
        win_q[j] <= win_q[j+1];
      end
      win_q[NK-1] <= nw;
      i_q <= i_q + 1'b1;
      k_q <= (k_q == 3'(NK - 1)) ? 3'd0 : k_q + 3'd1;
      if (k_q == 3'd0) begin
        rcon_q <= rcon_nx;
      end
      if (last) begin
        valid <= 1'b1;
      end
    end
  end

  for (genvar j = 0; j < W; j++) begin : g_exp
    assign expansion[(W-j)*32-1 -: 32] = w_q[j];
  end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Scoreboard bench for key_schedule_seq with AES-128/192/256 instances.
// Stimulus pushes expected results; per-instance monitors check on done.

module tb_key_schedule_seq;

  typedef struct {
    int unsigned  due;
    logic [127:0] rk0;
    logic [127:0] rk1;
    logic [127:0] last;
    bit           c1;
  } exp_t;

  localparam logic [127:0] K128A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK1A  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] LASTA = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K128B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1B  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] LASTB = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KX    = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [191:0] K192  =
    192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] LAST6 = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [255:0] K256  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RK1_8 = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] LAST8 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  logic clk = 1'b0;
  logic reset;
  logic start4, start6, start8;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic busy4, done4, valid4;
  logic busy6, done6, valid6;
  logic busy8, done8, valid8;
  logic [1407:0] exp4;
  logic [1663:0] exp6;
  logic [1919:0] exp8;

  int unsigned cyc = 0;
  int tests = 0;
  int fails = 0;
  bit prev4 = 0, prev6 = 0, prev8 = 0;

  exp_t q4[$];
  exp_t q6[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_schedule_seq #(.NK(4), .NR(10)) u4 (
    .clk(clk), .reset(reset), .start(start4), .key(key4),
    .busy(busy4), .done(done4), .valid(valid4), .expansion(exp4)
  );
  key_schedule_seq #(.NK(6), .NR(12)) u6 (
    .clk(clk), .reset(reset), .start(start6), .key(key6),
    .busy(busy6), .done(done6), .valid(valid6), .expansion(exp6)
  );
  key_schedule_seq #(.NK(8), .NR(14)) u8 (
    .clk(clk), .reset(reset), .start(start8), .key(key8),
    .busy(busy8), .done(done8), .valid(valid8), .expansion(exp8)
  );

  task automatic chk_v(input string nm, input logic [127:0] act,
                       input logic [127:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic chk_n(input string nm, input int unsigned act,
                       input int unsigned want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic no_exp(input string nm, input int unsigned c);
    tests++;
    fails++;
    $display("FAIL %s: got done at cycle %0d want none", nm, c);
  endtask

  function automatic exp_t mk(input int unsigned due, input logic [127:0] r0,
                              input logic [127:0] r1, input logic [127:0] rl,
                              input bit c1);
    exp_t e;
    e.due  = due;
    e.rk0  = r0;
    e.rk1  = r1;
    e.last = rl;
    e.c1   = c1;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (prev4) chk_v("nk4_done_pulse", {127'b0, done4}, 128'd0);
    if (done4) begin
      if (q4.size() == 0) no_exp("nk4_unexpected_done", cyc);
      else begin
        e = q4.pop_front();
        chk_n("nk4_latency", cyc, e.due);
        chk_v("nk4_rk0", exp4[1407 -: 128], e.rk0);
        if (e.c1) chk_v("nk4_rk1", exp4[1279 -: 128], e.rk1);
        chk_v("nk4_last", exp4[127:0], e.last);
        chk_v("nk4_valid", {127'b0, valid4}, 128'd1);
        chk_v("nk4_busy", {127'b0, busy4}, 128'd0);
      end
    end
    prev4 = done4;
  end

  always @(negedge clk) begin
    exp_t e;
    if (prev6) chk_v("nk6_done_pulse", {127'b0, done6}, 128'd0);
    if (done6) begin
      if (q6.size() == 0) no_exp("nk6_unexpected_done", cyc);
      else begin
        e = q6.pop_front();
        chk_n("nk6_latency", cyc, e.due);
        chk_v("nk6_rk0", exp6[1663 -: 128], e.rk0);
        if (e.c1) chk_v("nk6_rk1", exp6[1535 -: 128], e.rk1);
        chk_v("nk6_last", exp6[127:0], e.last);
        chk_v("nk6_valid", {127'b0, valid6}, 128'd1);
      end
    end
    prev6 = done6;
  end

  always @(negedge clk) begin
    exp_t e;
    if (prev8) chk_v("nk8_done_pulse", {127'b0, done8}, 128'd0);
    if (done8) begin
      if (q8.size() == 0) no_exp("nk8_unexpected_done", cyc);
      else begin
        e = q8.pop_front();
        chk_n("nk8_latency", cyc, e.due);
        chk_v("nk8_rk0", exp8[1919 -: 128], e.rk0);
        if (e.c1) chk_v("nk8_rk1", exp8[1791 -: 128], e.rk1);
        chk_v("nk8_last", exp8[127:0], e.last);
        chk_v("nk8_valid", {127'b0, valid8}, 128'd1);
      end
    end
    prev8 = done8;
  end

  task automatic drain(input string nm);
    int n = 0;
    while ((q4.size() + q6.size() + q8.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if ((q4.size() + q6.size() + q8.size()) != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d pending want 0",
               nm, q4.size() + q6.size() + q8.size());
      q4.delete();
      q6.delete();
      q8.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned c0;
    reset  = 1'b1;
    start4 = 1'b0;
    start6 = 1'b0;
    start8 = 1'b0;
    key4   = '0;
    key6   = '0;
    key8   = '0;
    repeat (3) @(negedge clk);
    chk_v("rst_busy", {127'b0, busy4}, 128'd0);
    chk_v("rst_done", {127'b0, done4}, 128'd0);
    chk_v("rst_valid", {127'b0, valid4}, 128'd0);
    chk_v("rst_valid8", {127'b0, valid8}, 128'd0);
    chk_v("rst_exp_zero", {127'b0, exp4 == '0}, 128'd1);
    reset = 1'b0;
    @(negedge clk);

    // three key sizes in parallel
    key4 = K128A; start4 = 1'b1;
    key6 = K192;  start6 = 1'b1;
    key8 = K256;  start8 = 1'b1;
    q4.push_back(mk(cyc + 41, K128A, RK1A, LASTA, 1'b1));
    q6.push_back(mk(cyc + 47, K128A, '0, LAST6, 1'b0));
    q8.push_back(mk(cyc + 53, K128A, RK1_8, LAST8, 1'b1));
    @(negedge clk);
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    chk_v("run_busy", {127'b0, busy4}, 128'd1);
    chk_v("run_valid", {127'b0, valid4}, 128'd0);
    drain("sizes");

    // FIPS key; second start mid-run must be ignored
    key4 = K128B; start4 = 1'b1;
    q4.push_back(mk(cyc + 41, K128B, RK1B, LASTB, 1'b1));
    @(negedge clk);
    start4 = 1'b0;
    repeat (18) @(negedge clk);
    key4 = KX; start4 = 1'b1;
    chk_v("ignore_busy", {127'b0, busy4}, 128'd1);
    @(negedge clk);
    start4 = 1'b0;
    drain("ignore");

    // restart from valid, then reset mid-run (no done expected)
    key4 = K128B; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk_v("restart_valid_drop", {127'b0, valid4}, 128'd0);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_v("midrst_busy", {127'b0, busy4}, 128'd0);
    chk_v("midrst_valid", {127'b0, valid4}, 128'd0);
    chk_v("midrst_exp_zero", {127'b0, exp4 == '0}, 128'd1);
    reset = 1'b0;
    @(negedge clk);
    key4 = K128A; start4 = 1'b1;
    q4.push_back(mk(cyc + 41, K128A, RK1A, LASTA, 1'b1));
    @(negedge clk);
    start4 = 1'b0;
    drain("post_reset");

    // start held high: back-to-back runs every 42 cycles
    key4 = K128B; start4 = 1'b1;
    c0 = cyc;
    q4.push_back(mk(c0 + 41, K128B, RK1B, LASTB, 1'b1));
    q4.push_back(mk(c0 + 83, K128B, RK1B, LASTB, 1'b1));
    q4.push_back(mk(c0 + 125, K128B, RK1B, LASTB, 1'b1));
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 42) chk_v("hold_valid_fin", {127'b0, valid4}, 128'd1);
      if (k == 44) chk_v("hold_valid_low", {127'b0, valid4}, 128'd0);
      if (k == 82) chk_v("hold_valid_late", {127'b0, valid4}, 128'd0);
    end
    start4 = 1'b0;
    drain("hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
